// File: rtl/maze_pkg.sv
// Shared definitions for the maze map store: FSM state encoding, plane geometry
// helpers and the row/col to linear cell index mapping.
package maze_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SOLVE = 3'd2,
        ST_DUMP  = 3'd3,
        ST_DONE  = 3'd4
    } maze_state_t;

    localparam int DEFAULT_WIDTH = 6;
    localparam int CELLS         = 1 << (2 * DEFAULT_WIDTH);
    localparam int BEATS         = CELLS / 8;

    function automatic int cells_of(input int w);
        return 1 << (2 * w);
    endfunction

    function automatic int beats_of(input int w);
        return cells_of(w) / 8;
    endfunction

    // Row-major: the row selects a block of 2^w cells, the column the cell inside it.
    function automatic logic [31:0] cell_index(input int w, input logic [31:0] r, input logic [31:0] c);
        return (r << w) | c;
    endfunction

endpackage

// File: rtl/maze_bit_plane.sv
// One bit plane of the maze map: byte-wide storage with per-bit write mask
// and a registered byte read that holds while rd_en is low.
module maze_bit_plane #(
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_mask,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    localparam int DEPTH = 1 << AW;

    logic [7:0] mem [DEPTH];

    // Read returns the pre-write contents when both ports hit the same byte.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                if (wr_mask[i]) begin
                    mem[wr_addr][i] <= wr_data[i];
                end
            end
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/maze_map_store.sv
// Maze map store: loads the wall bitmap, serves solver reads/path marks, then
// streams the path plane out. Optional distinct-cell counter under MAZE_PATH_COUNT_EN.
module maze_map_store
    import maze_pkg::*;
#(
    parameter int MAZE_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic [7:0]            ld_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [MAZE_WIDTH-1:0] row,
    input  logic [MAZE_WIDTH-1:0] col,
    input  logic                  maze_oe,
    input  logic                  maze_we,
    output logic                  maze_in,
    input  logic                  done,
    output logic                  solve_active,
    output logic [7:0]            dump_data,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic                  dump_last
`ifdef MAZE_PATH_COUNT_EN
    ,
    output logic [2*MAZE_WIDTH:0] path_count
`endif
);

    localparam int CW    = 2 * MAZE_WIDTH;
    localparam int AW    = CW - 3;
    localparam int NBEAT = beats_of(MAZE_WIDTH);

    maze_state_t   state_reg, state_next;
    logic [AW-1:0] ld_cnt_reg;
    logic [AW-1:0] dump_ptr_reg;
    logic          dump_valid_reg, dump_last_reg;
    logic          started_reg, rd_hit_reg;
    logic [2:0]    rd_bit_reg;
    logic [CW-1:0] cell_idx;
    logic [AW-1:0] cell_byte;
    logic [2:0]    cell_bit;
    logic          ld_acc, load_go, solve_rd, solve_wr, dump_rd;
    logic [7:0]    wall_rd, path_rd;

    assign cell_idx  = CW'(cell_index(MAZE_WIDTH, 32'(row), 32'(col)));
    assign cell_byte = cell_idx[CW-1:3];
    assign cell_bit  = cell_idx[2:0];

    assign load_go  = ((state_reg == ST_IDLE) || (state_reg == ST_DONE)) && load_start;
    assign ld_acc   = (state_reg == ST_LOAD) && ld_valid;
    assign solve_rd = (state_reg == ST_SOLVE) && maze_oe;
    assign solve_wr = (state_reg == ST_SOLVE) && maze_we;
    // Fetch the next word whenever the output slot is empty or being consumed.
    assign dump_rd  = (state_reg == ST_DUMP) && (!dump_valid_reg || dump_ready) && !dump_last_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: if (load_start) state_next = ST_LOAD;
            ST_LOAD:  if (ld_valid && (ld_cnt_reg == AW'(NBEAT - 1))) state_next = ST_SOLVE;
            ST_SOLVE: if (done) state_next = ST_DUMP;
            ST_DUMP:  if (dump_valid_reg && dump_ready && dump_last_reg) state_next = ST_DONE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt_reg <= '0;
        end else if (state_reg != ST_LOAD) begin
            ld_cnt_reg <= '0;
        end else if (ld_valid) begin
            ld_cnt_reg <= ld_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dump_ptr_reg   <= '0;
            dump_valid_reg <= 1'b0;
            dump_last_reg  <= 1'b0;
        end else if (state_reg != ST_DUMP) begin
            dump_ptr_reg   <= '0;
            dump_valid_reg <= 1'b0;
            dump_last_reg  <= 1'b0;
        end else if (dump_rd) begin
            dump_ptr_reg   <= dump_ptr_reg + 1'b1;
            dump_valid_reg <= 1'b1;
            dump_last_reg  <= (dump_ptr_reg == AW'(NBEAT - 1));
        end else if (dump_valid_reg && dump_ready) begin
            dump_valid_reg <= 1'b0;
            dump_last_reg  <= 1'b0;
        end
    end

    // The wall read register holds between strobes, so maze_in holds with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_reg <= 1'b0;
            rd_hit_reg  <= 1'b0;
            rd_bit_reg  <= '0;
        end else begin
            started_reg <= 1'b1;
            if (state_reg != ST_SOLVE) begin
                rd_hit_reg <= 1'b0;
            end else if (maze_oe) begin
                rd_hit_reg <= 1'b1;
                rd_bit_reg <= cell_bit;
            end
        end
    end

    assign maze_in      = (state_reg == ST_SOLVE) ? (rd_hit_reg ? wall_rd[rd_bit_reg] : 1'b1) : started_reg;
    assign ld_ready     = (state_reg == ST_LOAD);
    assign solve_active = (state_reg == ST_SOLVE);
    assign dump_valid   = dump_valid_reg;
    assign dump_last    = dump_last_reg;
    assign dump_data    = dump_valid_reg ? path_rd : 8'h00;

    maze_bit_plane #(.AW(AW)) u_wall (
        .clk     (clk),
        .we      (ld_acc),
        .wr_addr (ld_cnt_reg),
        .wr_mask (8'hff),
        .wr_data (ld_data),
        .rd_en   (solve_rd),
        .rd_addr (cell_byte),
        .rd_data (wall_rd)
    );

    // Path plane: cleared bytewise during load, marked bitwise during solve.
    maze_bit_plane #(.AW(AW)) u_path (
        .clk     (clk),
        .we      (ld_acc || solve_wr),
        .wr_addr (ld_acc ? ld_cnt_reg : cell_byte),
        .wr_mask (ld_acc ? 8'hff : 8'(8'h01 << cell_bit)),
        .wr_data (ld_acc ? 8'h00 : 8'hff),
        .rd_en   (dump_rd || solve_wr),
        .rd_addr (dump_rd ? dump_ptr_reg : cell_byte),
        .rd_data (path_rd)
    );

`ifdef MAZE_PATH_COUNT_EN
    localparam int CNTW = CW + 1;

    logic            pend_reg;
    logic [2:0]      pend_bit_reg;
    logic [CNTW-1:0] count_reg;

    // A mark reads the old path byte in the same cycle; the count decides one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg     <= 1'b0;
            pend_bit_reg <= '0;
            count_reg    <= '0;
        end else begin
            pend_reg     <= solve_wr;
            pend_bit_reg <= cell_bit;
            if (load_go) begin
                count_reg <= '0;
            end else if (pend_reg && !path_rd[pend_bit_reg] && (count_reg < CNTW'(cells_of(MAZE_WIDTH)))) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign path_count = count_reg;
`else
    logic unused_load_go;
    assign unused_load_go = load_go;
`endif

endmodule

// File: tb/tb_maze_map_store.sv
// Randomised self-checking bench for maze_map_store against a cell-level
// behavioural model of load, solve and dump phases.
module tb_maze_map_store;

    localparam int W     = 6;
    localparam int CELLS = 1 << (2 * W);
    localparam int BEATS = CELLS / 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load_start = 1'b0;
    logic [7:0]   ld_data = 8'h00;
    logic         ld_valid = 1'b0;
    logic         ld_ready;
    logic [W-1:0] row = '0;
    logic [W-1:0] col = '0;
    logic         maze_oe = 1'b0;
    logic         maze_we = 1'b0;
    logic         maze_in;
    logic         done = 1'b0;
    logic         solve_active;
    logic [7:0]   dump_data;
    logic         dump_valid;
    logic         dump_ready = 1'b0;
    logic         dump_last;
`ifdef MAZE_PATH_COUNT_EN
    logic [2*W:0] path_count;
`endif

    maze_map_store #(.MAZE_WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start   (load_start),
        .ld_data      (ld_data),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .row          (row),
        .col          (col),
        .maze_oe      (maze_oe),
        .maze_we      (maze_we),
        .maze_in      (maze_in),
        .done         (done),
        .solve_active (solve_active),
        .dump_data    (dump_data),
        .dump_valid   (dump_valid),
        .dump_ready   (dump_ready),
        .dump_last    (dump_last)
`ifdef MAZE_PATH_COUNT_EN
        ,
        .path_count   (path_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef enum int {M_IDLE, M_LOAD, M_SOLVE, M_DUMP, M_DONE} mphase_t;
    mphase_t    m_state = M_IDLE;
    bit         m_wall [CELLS];
    bit         m_path [CELLS];
    int         m_beat = 0;
    int         m_count = 0;
    int         m_dptr = 0;
    bit         m_dv = 0;
    bit         m_mi = 1;
    bit         m_started = 0;
    logic [7:0] map_bytes [BEATS];
    logic [7:0] got [$];
    int         got_last_n = 0;
    int         got_last_idx = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] path_byte(input int b);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = m_path[b*8 + k];
        return r;
    endfunction

    // Behavioural model: advances once per rising edge from the sampled inputs.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_state = M_IDLE; m_started = 0; m_dv = 0; m_count = 0; m_mi = 1; m_dptr = 0;
            end else begin
                m_started = 1;
                case (m_state)
                    M_IDLE, M_DONE: if (load_start) begin
                        m_state = M_LOAD; m_beat = 0; m_count = 0;
                    end
                    M_LOAD: if (ld_valid) begin
                        for (int k = 0; k < 8; k++) begin
                            m_wall[m_beat*8 + k] = ld_data[k];
                            m_path[m_beat*8 + k] = 1'b0;
                        end
                        m_beat++;
                        if (m_beat == BEATS) begin
                            m_state = M_SOLVE; m_mi = 1;
                        end
                    end
                    M_SOLVE: begin
                        int idx;
                        idx = int'(row) * (1 << W) + int'(col);
                        if (maze_oe) m_mi = m_wall[idx];
                        if (maze_we) begin
                            if (!m_path[idx] && m_count < CELLS) m_count++;
                            m_path[idx] = 1'b1;
                        end
                        if (done) begin
                            m_state = M_DUMP; m_dv = 0; m_dptr = 0;
                        end
                    end
                    M_DUMP: begin
                        if (!m_dv) begin
                            m_dv = 1; m_dptr = 0;
                        end else if (dump_ready) begin
                            if (m_dptr == BEATS - 1) begin
                                m_state = M_DONE; m_dv = 0;
                            end else begin
                                m_dptr++;
                            end
                        end
                    end
                    default: m_state = M_IDLE;
                endcase
            end
        end
    end

    // Per-cycle compare against the model, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            check("ld_ready", 32'(ld_ready), 32'(m_state == M_LOAD));
            check("solve_active", 32'(solve_active), 32'(m_state == M_SOLVE));
            check("maze_in", 32'(maze_in), 32'((m_state == M_SOLVE) ? m_mi : m_started));
            check("dump_valid", 32'(dump_valid), 32'(m_dv));
            if (m_dv) begin
                check("dump_data", 32'(dump_data), 32'(path_byte(m_dptr)));
                check("dump_last", 32'(dump_last), 32'(m_dptr == BEATS - 1));
            end else begin
                check("dump_last_idle", 32'(dump_last), 32'd0);
            end
            if (!rst_n) check("rst_dump_data", 32'(dump_data), 32'd0);
`ifdef MAZE_PATH_COUNT_EN
            if (m_state == M_IDLE || m_state == M_LOAD || m_state == M_DONE || (m_state == M_DUMP && m_dv))
                check("path_count", 32'(path_count), 32'(m_count));
`endif
            if (dump_valid && dump_ready) begin
                got.push_back(dump_data);
                if (dump_last) begin
                    got_last_n++;
                    got_last_idx = got.size() - 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input bit gaps);
        int b, cyc;
        bit v;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        b = 0; cyc = 0;
        while (b < BEATS && cyc < 5000) begin
            v = gaps ? ($urandom_range(3) != 0) : 1'b1;
            ld_valid = v;
            ld_data  = v ? map_bytes[b] : 8'($urandom);
            tick();
            if (v) b++;
            cyc++;
        end
        ld_valid = 1'b0;
        if (cyc >= 5000) begin
            errors++;
            $display("FAIL load_timeout: got %0d beats expected %0d", b, BEATS);
        end
    endtask

    task automatic run_dump(input bit random_ready, input bit stall_mid, input bit poke_oe);
        int cyc;
        got.delete();
        got_last_n = 0;
        got_last_idx = -1;
        cyc = 0;
        while (m_state != M_DONE && cyc < 5000) begin
            if (stall_mid && cyc >= 100 && cyc < 103) dump_ready = 1'b0;
            else dump_ready = random_ready ? ($urandom_range(3) != 0) : 1'b1;
            maze_oe = poke_oe ? 1'($urandom) : 1'b0;
            maze_we = poke_oe ? 1'($urandom) : 1'b0;
            row = W'($urandom); col = W'($urandom);
            tick();
            if (poke_oe && m_state == M_DUMP && m_dv) check("t5_dump_oe_wall", 32'(maze_in), 32'd1);
            cyc++;
        end
        dump_ready = 1'b0; maze_oe = 1'b0; maze_we = 1'b0;
        if (cyc >= 5000) begin
            errors++;
            $display("FAIL dump_timeout: got %0d beats expected %0d", got.size(), BEATS);
        end
        check("dump_beats", 32'(got.size()), 32'(BEATS));
        check("dump_last_once", 32'(got_last_n), 32'd1);
        check("dump_last_pos", 32'(got_last_idx), 32'(BEATS - 1));
    endtask

    initial begin
        logic [7:0] acc;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ld_ready", 32'(ld_ready), 32'd0);
        check("rst_maze_in", 32'(maze_in), 32'd0);
        check("rst_dump_valid", 32'(dump_valid), 32'd0);
        rst_n = 1'b1;
        tick();

        // T1: reset during load
        load_start = 1'b1; tick(); load_start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            ld_valid = 1'b1; ld_data = 8'($urandom); tick();
        end
        ld_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t1_ld_ready", 32'(ld_ready), 32'd0);
        check("t1_solve_active", 32'(solve_active), 32'd0);
        check("t1_dump_valid", 32'(dump_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t1_maze_in", 32'(maze_in), 32'd1);
        check("t1_ld_ready_after", 32'(ld_ready), 32'd0);

        // T2: single wall at cell 0
        for (int i = 0; i < BEATS; i++) map_bytes[i] = 8'h00;
        map_bytes[0] = 8'h01;
        do_load(1'b0);
        check("t2_solve_active", 32'(solve_active), 32'd1);
        row = 0; col = 0; maze_oe = 1'b1; tick();
        check("t2_oe_00", 32'(maze_in), 32'd1);
        row = 0; col = 1; tick();
        check("t2_oe_01", 32'(maze_in), 32'd0);
        maze_oe = 1'b0; tick();
        check("t2_hold", 32'(maze_in), 32'd0);

        // T3: marks then dump
        maze_we = 1'b1;
        row = 0; col = 5; tick();
        tick();
        row = 1; col = 0; tick();
        maze_we = 1'b0; done = 1'b1; tick(); done = 1'b0;
        run_dump(1'b0, 1'b0, 1'b0);
        check("t3_beat0", 32'(got[0]), 32'h20);
        check("t3_beat8", 32'(got[8]), 32'h01);
        check("t3_beat1", 32'(got[1]), 32'h00);
`ifdef MAZE_PATH_COUNT_EN
        check("t3_path_count", 32'(path_count), 32'd2);
`endif

        // T6: reload zero map from DONE, path plane must be cleared
        for (int i = 0; i < BEATS; i++) map_bytes[i] = 8'h00;
        do_load(1'b1);
        done = 1'b1; tick(); done = 1'b0;
        run_dump(1'b1, 1'b0, 1'b0);
        acc = 8'h00;
        foreach (got[i]) acc = acc | got[i];
        check("t6_zero_path", 32'(acc), 32'd0);

        // T5 + random solve, T4 stall during dump
        for (int i = 0; i < BEATS; i++) map_bytes[i] = 8'($urandom);
        map_bytes[16] = map_bytes[16] | 8'h08;
        do_load(1'b1);
        row = 2; col = 3; maze_oe = 1'b1; maze_we = 1'b1; tick();
        check("t5_oe_we_wall", 32'(maze_in), 32'd1);
        maze_we = 1'b0; tick();
        check("t5_wall_kept", 32'(maze_in), 32'd1);
        for (int i = 0; i < 300; i++) begin
            maze_oe = 1'($urandom); maze_we = 1'($urandom);
            row = W'($urandom); col = W'($urandom);
            tick();
        end
        maze_oe = 1'b0; maze_we = 1'b1; done = 1'b1;
        row = W'($urandom); col = W'($urandom);
        tick();
        maze_we = 1'b0; done = 1'b0;
        run_dump(1'b1, 1'b1, 1'b1);
        check("t5_path_bit", 32'(got[16][3]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
